alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 111 +++++++++++
 tb/tb_alu_issue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue stage for an external 8-bit ALU: 8x8 register file, IDLE->EXEC->WB sequencer.
// Result lands in r[rd] two edges after accept; instr_ready is low outside IDLE or while a direct load is requested.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [18:0] instr,
  output logic        instr_ready,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic [3:0]  alu_ctrl,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        carry_flag,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  state_e      state_q, state_d;
  logic [7:0]  regs_q [8];
  logic [3:0]  ctrl_q;
  logic [2:0]  rd_q;
  logic [7:0]  x_q, y_q;
  logic [7:0]  res_q;
  logic        cstage_q;
  logic        carry_q;

  logic        accept;
  logic [3:0]  in_ctrl;
  logic [2:0]  in_rd, in_rs1;
  logic        in_imm;
  logic [7:0]  in_op2;
  logic [7:0]  in_y;

  assign in_ctrl = instr[18:15];
  assign in_rd   = instr[14:12];
  assign in_rs1  = instr[11:9];
  assign in_imm  = instr[8];
  assign in_op2  = instr[7:0];
  assign in_y    = in_imm ? in_op2 : regs_q[in_op2[2:0]];

  assign instr_ready = (state_q == S_IDLE) & ~ld_en;
  assign accept      = instr_valid & instr_ready;

  // Operand latches drive the ALU continuously so the outputs never drop to zero between instructions.
  assign alu_ctrl   = ctrl_q;
  assign alu_x      = x_q;
  assign alu_y      = y_q;
  assign rd_data    = regs_q[rd_addr];
  assign carry_flag = carry_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_WB);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= 4'h0;
      rd_q     <= 3'd0;
      x_q      <= 8'h00;
      y_q      <= 8'h00;
      res_q    <= 8'h00;
      cstage_q <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_q <= in_ctrl;
        rd_q   <= in_rd;
        x_q    <= regs_q[in_rs1];
        y_q    <= in_y;
      end
      if (state_q == S_EXEC) begin
        res_q    <= alu_out;
        cstage_q <= alu_carry;
      end
    end
  end

  // WB and direct loads never coincide: loads are only honoured in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
      carry_q <= 1'b0;
    end else if (state_q == S_WB) begin
      regs_q[rd_q] <= res_q;
      if (ctrl_q[3:1] == 3'b000) carry_q <= cstage_q;
    end else if (state_q == S_IDLE && ld_en) begin
      regs_q[ld_addr] <= ld_data;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue with an attached 8-bit ALU: directed table, hand sequences, random run vs register model.
module tb_alu_issue;

  logic        clk, rst_n;
  logic        instr_valid;
  logic [18:0] instr;
  logic        instr_ready;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [3:0]  alu_ctrl;
  logic [7:0]  alu_x, alu_y, alu_out;
  logic        alu_carry;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        carry_flag, busy, done;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_r [8];
  logic       m_c;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out),
    .alu_carry(alu_carry), .rd_addr(rd_addr), .rd_data(rd_data),
    .carry_flag(carry_flag), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: {carry, result}. Non add/sub ops report carry=1 so a wrongly updated flag shows up.
  function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    case (c)
      4'h0: return {1'b0, x} + {1'b0, y};
      4'h1: return {1'b0, x} - {1'b0, y};
      4'h2: return {1'b1, x & y};
      4'h3: return {1'b1, x | y};
      4'h4: return {1'b1, x ^ y};
      4'h6: return {1'b1, ~(x | y)};
      4'h7: return {1'b1, y};
      4'h8: return {1'b1, x[6:0], 1'b0};
      4'h9: return {1'b1, 1'b0, x[7:1]};
      default: return 9'h100;
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic scan_regs(input string nm);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), d);
      chk($sformatf("%s_r%0d", nm, i), {24'h0, d}, {24'h0, m_r[i]});
    end
  endtask

  // Called and returns at posedge+1 with the DUT idle.
  task automatic do_load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_r[a] = d;
  endtask

  task automatic run_instr(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic imm, input logic [7:0] op2, input bit ld_exec, input string nm);
    logic [7:0] x, y, d;
    logic [8:0] r;
    x = m_r[rs1];
    y = imm ? op2 : m_r[op2[2:0]];
    r = alu_fn(c, x, y);
    instr_valid = 1'b1;
    instr = {c, rd, rs1, imm, op2};
    #1;
    chk({nm, "_ready"}, {31'h0, instr_ready}, 32'h1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (ld_exec) begin
      ld_en = 1'b1; ld_addr = 3'($urandom_range(0, 7)); ld_data = 8'($urandom);
    end
    chk({nm, "_exec_busy"}, {31'h0, busy}, 32'h1);
    chk({nm, "_exec_done"}, {31'h0, done}, 32'h0);
    chk({nm, "_exec_ctrl"}, {28'h0, alu_ctrl}, {28'h0, c});
    chk({nm, "_exec_x"}, {24'h0, alu_x}, {24'h0, x});
    chk({nm, "_exec_y"}, {24'h0, alu_y}, {24'h0, y});
    @(posedge clk); #1;
    chk({nm, "_wb_done"}, {31'h0, done}, 32'h1);
    read_reg(rd, d);
    chk({nm, "_wb_nobypass"}, {24'h0, d}, {24'h0, m_r[rd]});
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_r[rd] = r[7:0];
    if (c[3:1] == 3'b000) m_c = r[8];
    chk({nm, "_idle_done"}, {31'h0, done}, 32'h0);
    chk({nm, "_idle_busy"}, {31'h0, busy}, 32'h0);
    chk({nm, "_hold_x"}, {24'h0, alu_x}, {24'h0, x});
    chk({nm, "_carry"}, {31'h0, carry_flag}, {31'h0, m_c});
    read_reg(rd, d);
    chk({nm, "_rd"}, {24'h0, d}, {24'h0, m_r[rd]});
  endtask

  typedef struct {
    bit         is_ld;
    logic [3:0] c;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic       imm;
    logic [7:0] op2;
    logic [7:0] exp_val;
    logic       exp_c;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [7:0] d;
    int acc;

    // {is_ld, ctrl, rd, rs1, imm, op2/ld_data, expected r[rd], expected carry}
    vecs[0]  = '{1, 4'h0, 3'd1, 3'd0, 1'b0, 8'h80, 8'h80, 1'b0};
    vecs[1]  = '{1, 4'h0, 3'd2, 3'd0, 1'b0, 8'h80, 8'h80, 1'b0};
    vecs[2]  = '{0, 4'h0, 3'd3, 3'd1, 1'b0, 8'h02, 8'h00, 1'b1};
    vecs[3]  = '{0, 4'h1, 3'd4, 3'd3, 1'b1, 8'h01, 8'hFF, 1'b1};
    vecs[4]  = '{0, 4'h6, 3'd5, 3'd4, 1'b0, 8'h04, 8'h00, 1'b1};
    vecs[5]  = '{0, 4'h0, 3'd6, 3'd5, 1'b0, 8'h05, 8'h00, 1'b0};
    vecs[6]  = '{1, 4'h0, 3'd2, 3'd0, 1'b0, 8'h33, 8'h33, 1'b0};
    vecs[7]  = '{0, 4'hF, 3'd2, 3'd1, 1'b0, 8'h02, 8'h00, 1'b0};
    vecs[8]  = '{0, 4'h0, 3'd1, 3'd1, 1'b1, 8'h80, 8'h00, 1'b1};
    vecs[9]  = '{0, 4'h2, 3'd7, 3'd4, 1'b1, 8'h3C, 8'h3C, 1'b1};
    vecs[10] = '{0, 4'h1, 3'd0, 3'd7, 1'b0, 8'h07, 8'h00, 1'b0};
    vecs[11] = '{0, 4'hE, 3'd7, 3'd7, 1'b0, 8'h00, 8'h00, 1'b0};

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_c = 1'b0;

    #2;
    chk("rst_ready", {31'h0, instr_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_carry", {31'h0, carry_flag}, 32'h0);
    chk("rst_alu", {12'h0, alu_ctrl, alu_x, alu_y}, 32'h0);
    scan_regs("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'h0, instr_ready}, 32'h1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_ld) do_load(vecs[i].rd, vecs[i].op2);
      else run_instr(vecs[i].c, vecs[i].rd, vecs[i].rs1, vecs[i].imm, vecs[i].op2, 1'b0,
                     $sformatf("vec%0d", i));
      read_reg(vecs[i].rd, d);
      chk($sformatf("vec%0d_val", i), {24'h0, d}, {24'h0, vecs[i].exp_val});
      chk($sformatf("vec%0d_cflag", i), {31'h0, carry_flag}, {31'h0, vecs[i].exp_c});
    end
    scan_regs("table");

    // Back-to-back: valid held high, r0 += 1 four times
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      instr_valid = 1'b1;
      instr = {4'h0, 3'd0, 3'd0, 1'b1, 8'h01};
      #1;
      chk($sformatf("b2b_ready_c%0d", c), {31'h0, instr_ready}, {31'h0, (c % 3) == 0});
      chk($sformatf("b2b_done_c%0d", c), {31'h0, done}, {31'h0, (c % 3) == 2});
      if (instr_ready) acc++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [8:0] r;
      r = alu_fn(4'h0, m_r[0], 8'h01);
      m_r[0] = r[7:0];
      m_c = r[8];
    end
    chk("b2b_accepts", acc, 4);
    read_reg(3'd0, d);
    chk("b2b_r0", {24'h0, d}, {24'h0, m_r[0]});
    chk("b2b_carry", {31'h0, carry_flag}, {31'h0, m_c});

    // Load wins over a simultaneous instruction, which is taken next cycle
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 8'h5A;
    instr_valid = 1'b1; instr = {4'h3, 3'd5, 3'd6, 1'b1, 8'h00};
    #1;
    chk("coll_ready", {31'h0, instr_ready}, 32'h0);
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_r[6] = 8'h5A;
    chk("coll_not_accepted", {31'h0, busy}, 32'h0);
    read_reg(3'd6, d);
    chk("coll_r6", {24'h0, d}, 32'h5A);
    run_instr(4'h3, 3'd5, 3'd6, 1'b1, 8'h00, 1'b1, "coll_instr");
    scan_regs("coll");

    // Reset in EXEC discards the in-flight ADD to r7
    instr_valid = 1'b1; instr = {4'h0, 3'd7, 3'd6, 1'b1, 8'h11};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("mid_rst_pre_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_c = 1'b0;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_carry", {31'h0, carry_flag}, 32'h0);
    chk("mid_rst_alu", {12'h0, alu_ctrl, alu_x, alu_y}, 32'h0);
    chk("mid_rst_ready", {31'h0, instr_ready}, 32'h1);
    scan_regs("mid_rst");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_rst_nodone%0d", c), {31'h0, done}, 32'h0);
    end
    rst_n = 1'b1;
    run_instr(4'h0, 3'd7, 3'd0, 1'b1, 8'h05, 1'b0, "post_rst_instr");

    // Randomized run against the register model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(3'($urandom_range(0, 7)), 8'($urandom));
      else
        run_instr(4'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
    end
    scan_regs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
